// File: rtl/arb_mux.sv
// arb_mux: NCH-channel arbiter/mux with explicit-select or round-robin grant,
// a registered output stage and valid/ready handshakes on both sides.
// Ports: clk, reset (sync, active-high), in_data/in_valid/in_ready (per channel),
//   rr_mode, sel, out_data/out_valid/out_ready, out_ch (source channel).
// Option macro ARB_MUX_SKID_EN: adds a skid entry so in_ready uses registered state only.
module arb_mux #(
  parameter int NBITS = 7,
  parameter int NCH = 2,
  localparam int SELW = (NCH > 2) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*NBITS-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 rr_mode,
  input  logic [SELW-1:0]      sel,
  output logic [NBITS-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_found;
  logic             can_acc;
  logic             acc;
  logic             pop;
  logic [NBITS-1:0] gnt_data;

  // Round-robin search starts just after the last accepted channel.
  always_comb begin
    int j;
    j = 0;
    gnt_found = 1'b0;
    gnt_idx = '0;
    if (rr_mode) begin
      for (int k = 1; k <= NCH; k++) begin
        j = (int'(rr_ptr) + k) % NCH;
        if (!gnt_found && in_valid[j]) begin
          gnt_found = 1'b1;
          gnt_idx = SELW'(j);
        end
      end
    end else if (int'(sel) < NCH) begin
      gnt_found = 1'b1;
      gnt_idx = sel;
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NCH; i++) begin
      in_ready[i] = gnt_found && can_acc && !reset
                    && (gnt_idx == SELW'(i));
    end
  end

  assign gnt_data = in_data[int'(gnt_idx)*NBITS +: NBITS];
  assign acc = |(in_valid & in_ready);
  assign pop = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= SELW'(NCH - 1);
    end else if (acc) begin
      rr_ptr <= gnt_idx;
    end
  end

`ifdef ARB_MUX_SKID_EN
  logic             skid_valid;
  logic [NBITS-1:0] skid_data;
  logic [SELW-1:0]  skid_ch;

  // Ready comes from registers only; a stalled output spills into the skid.
  assign can_acc = !skid_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_ch     <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ch    <= '0;
    end else if (!out_valid || pop) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_ch     <= skid_ch;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (acc) begin
        out_data  <= gnt_data;
        out_ch    <= gnt_idx;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_data  <= gnt_data;
      skid_ch    <= gnt_idx;
      skid_valid <= 1'b1;
    end
  end
`else
  assign can_acc = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (acc) begin
      out_data  <= gnt_data;
      out_ch    <= gnt_idx;
      out_valid <= 1'b1;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed bench for arb_mux with a queue-based reference model
// checked every cycle, plus literal expectations; a second NCH=3 instance.
module tb_arb_mux;

  localparam int NB = 7;
  localparam int NC = 4;
  localparam int SW = 2;
`ifdef ARB_MUX_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [NC*NB-1:0] in_data;
  logic [NC-1:0] in_valid, in_ready;
  logic rr_mode;
  logic [SW-1:0] sel;
  logic [NB-1:0] out_data;
  logic out_valid, out_ready;
  logic [SW-1:0] out_ch;

  logic [3*NB-1:0] in_data3;
  logic [2:0] in_valid3, in_ready3;
  logic rr_mode3;
  logic [1:0] sel3;
  logic [NB-1:0] out_data3;
  logic out_valid3, out_ready3;
  logic [1:0] out_ch3;

  arb_mux #(.NBITS(NB), .NCH(NC)) u_dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .rr_mode(rr_mode), .sel(sel),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  arb_mux #(.NBITS(NB), .NCH(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .rr_mode(rr_mode3), .sel(sel3),
    .out_data(out_data3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_ch(out_ch3)
  );

  typedef struct packed {
    logic [NB-1:0] d;
    logic [SW-1:0] ch;
  } word_t;

  word_t q[$];
  int m_rr;
  int errors = 0;
  int checks = 0;
  int dut_acc;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic int grant_m();
    if (!rr_mode) return (int'(sel) < NC) ? int'(sel) : -1;
    for (int k = 1; k <= NC; k++) begin
      int j;
      j = (m_rr + k) % NC;
      if (in_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [NC-1:0] rdy_m(input int g);
    logic [NC-1:0] r;
    logic room;
    r = '0;
    if (DEPTH == 2) room = (q.size() < 2);
    else room = (q.size() == 0) || out_ready;
    if (!reset && g >= 0 && room) r[g] = 1'b1;
    return r;
  endfunction

  // One clock: compare at negedge, advance model at posedge.
  task automatic cyc();
    int g;
    logic [NC-1:0] r;
    @(negedge clk);
    g = grant_m();
    r = rdy_m(g);
    chk("in_ready", 32'(in_ready), 32'(r));
    chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("out_data", 32'(out_data), 32'(q[0].d));
      chk("out_ch", 32'(out_ch), 32'(q[0].ch));
    end
    @(posedge clk);
    if (reset) begin
      q.delete();
      m_rr = NC - 1;
    end else begin
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (|(in_valid & r)) begin
        q.push_back({in_data[g*NB +: NB], SW'(g)});
        m_rr = g;
      end
    end
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  typedef struct {
    logic rr;
    logic [SW-1:0] s;
    logic [NC-1:0] v;
    logic ordy;
  } vec_t;

  vec_t tbl[10];
  int seq[5];

  initial begin
    reset = 1'b1;
    in_data = '0; in_valid = '0; rr_mode = 1'b0;
    sel = '0; out_ready = 1'b1;
    in_data3 = '0; in_valid3 = '0; rr_mode3 = 1'b0;
    sel3 = '0; out_ready3 = 1'b1;
    m_rr = NC - 1;
    @(posedge clk);
    #1;
    cyc();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    in_valid = 4'b1111;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;

    // Explicit select of channel 2
    rr_mode = 1'b0; sel = 2'd2; in_valid = 4'b1111;
    in_data = {7'h44, 7'h55, 7'h22, 7'h11};
    #1;
    chk("expl_in_ready", 32'(in_ready), 32'h4);
    cyc();
    chk("expl_out_data", 32'(out_data), 32'h55);
    chk("expl_out_ch", 32'(out_ch), 32'd2);

    // Round-robin from reset, all channels valid
    pulse_reset();
    rr_mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {7'h33, 7'h32, 7'h31, 7'h30};
    seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("rr_seq_ch", 32'(out_ch), 32'(seq[i]));
      chk("rr_seq_valid", 32'(out_valid), 32'd1);
    end

    // Round-robin: ch3 alone, then ch1 alone
    pulse_reset();
    rr_mode = 1'b1; in_valid = 4'b1000;
    #1;
    chk("rr3_in_ready", 32'(in_ready), 32'h8);
    cyc();
    chk("rr3_out_ch", 32'(out_ch), 32'd3);
    in_valid = 4'b0010;
    #1;
    chk("rr1_in_ready", 32'(in_ready), 32'h2);
    cyc();
    chk("rr1_out_ch", 32'(out_ch), 32'd1);
    in_valid = 4'b1111;
    #1;
    chk("rr_ptr1_next", 32'(in_ready), 32'h4);
    cyc();

    // Output stall while ch0 streams
    pulse_reset();
    rr_mode = 1'b0; sel = 2'd0; in_valid = 4'b0001;
    out_ready = 1'b0; dut_acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_data[NB-1:0] = NB'(8'h20 + i);
      #1;
      if (|(in_valid & in_ready)) dut_acc++;
      cyc();
      chk("stall_data", 32'(out_data), 32'h20);
    end
    chk("stall_accepted", 32'(dut_acc), 32'(DEPTH));
    out_ready = 1'b1; in_valid = '0;
    for (int i = 0; i < 3; i++) cyc();

    // Reset while holding a stalled word
    rr_mode = 1'b0; sel = 2'd1; in_valid = 4'b0010;
    in_data[2*NB-1:NB] = 7'h11; out_ready = 1'b0;
    cyc();
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_ch", 32'(out_ch), 32'd1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_ch", 32'(out_ch), 32'd0);
    rr_mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
    #1;
    chk("post_rst_grant", 32'(in_ready), 32'h1);
    cyc();
    chk("post_rst_ch", 32'(out_ch), 32'd0);

    // NCH=3 instance: out-of-range select
    in_valid = '0;
    rr_mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    in_data3 = {7'h63, 7'h62, 7'h61};
    #1;
    chk("oor_in_ready", 32'(in_ready3), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("oor_out_valid", 32'(out_valid3), 32'd0);
    end
    sel3 = 2'd2;
    #1;
    chk("n3_in_ready", 32'(in_ready3), 32'h4);
    cyc();
    chk("n3_out_valid", 32'(out_valid3), 32'd1);
    chk("n3_out_ch", 32'(out_ch3), 32'd2);
    chk("n3_out_data", 32'(out_data3), 32'h63);
    in_valid3 = '0;

    // Mixed directed vectors, model-checked
    tbl[0] = '{1'b1, 2'd0, 4'b0101, 1'b1};
    tbl[1] = '{1'b1, 2'd0, 4'b0101, 1'b0};
    tbl[2] = '{1'b1, 2'd0, 4'b0101, 1'b0};
    tbl[3] = '{1'b0, 2'd3, 4'b1000, 1'b1};
    tbl[4] = '{1'b1, 2'd0, 4'b0000, 1'b1};
    tbl[5] = '{1'b0, 2'd1, 4'b0000, 1'b1};
    tbl[6] = '{1'b1, 2'd2, 4'b1110, 1'b0};
    tbl[7] = '{1'b1, 2'd2, 4'b1110, 1'b1};
    tbl[8] = '{1'b1, 2'd2, 4'b1110, 1'b1};
    tbl[9] = '{1'b0, 2'd0, 4'b0000, 1'b1};
    for (int i = 0; i < 10; i++) begin
      rr_mode = tbl[i].rr; sel = tbl[i].s;
      in_valid = tbl[i].v; out_ready = tbl[i].ordy;
      in_data = (NC*NB)'({$urandom, $urandom});
      cyc();
    end
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 The module SHALL have parameter NBITS, default 7, giving the data width per channel.
REQ-002 The module SHALL have parameter NCH, default 2, giving the number of input channels, legal range 2..16.
REQ-003 The module SHALL have derived localparam SELW = max(1, clog2(NCH)), giving the channel index width.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port in_data, input, NCH*NBITS bits: channel i occupies bits [i*NBITS +: NBITS].
REQ-007 The module SHALL have port in_valid, input, NCH bits: per-channel valid.
REQ-008 The module SHALL have port in_ready, output, NCH bits: per-channel ready.
REQ-009 The module SHALL have port rr_mode, input, 1 bit: 0 = explicit select, 1 = round-robin.
REQ-010 The module SHALL have port sel, input, SELW bits: the channel index used in explicit mode.
REQ-011 The module SHALL have port out_data, output, NBITS bits: registered output data.
REQ-012 The module SHALL have port out_valid, output, 1 bit: output valid.
REQ-013 The module SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-014 The module SHALL have port out_ch, output, SELW bits: source channel of out_data.

Function
REQ-015 A transfer on channel i SHALL occur on a clock edge where in_valid[i] and in_ready[i] are both 1; the output side transfers when out_valid and out_ready are both 1.
REQ-016 At most one in_ready bit SHALL be 1 in any cycle, and only for the granted channel.
REQ-017 Explicit mode: the granted channel SHALL be sel; if sel >= NCH, no channel is granted and in_ready is all 0.
REQ-018 Round-robin mode: the granted channel SHALL be the first channel with in_valid=1, searching from rr_ptr+1 upward and wrapping at NCH-1 to 0.
REQ-019 If no in_valid bit is 1 in round-robin mode, no channel is granted.
REQ-020 rr_ptr SHALL update to the granted channel index only on an accepted input transfer, and SHALL hold otherwise, including in explicit mode.
REQ-021 Grant SHALL be combinational from in_valid, rr_mode, sel and internal state; a change of rr_mode or sel SHALL affect only the current cycle's grant and SHALL never alter held data.
REQ-022 Latency SHALL be one cycle: data accepted at edge k appears on out_data/out_ch with out_valid=1 after edge k.
REQ-023 out_data, out_ch and out_valid SHALL be held stable while out_valid=1 and out_ready=0.
REQ-024 With an empty output stage and out_ready=0, one transfer SHALL be accepted, after which out_valid=1.
REQ-025 With a full output stage and simultaneous output and input transfers in one cycle, the new word SHALL replace the old with no bubble.
REQ-026 Data SHALL leave the block in acceptance order; no word is dropped or duplicated.

Reset
REQ-027 While reset=1 at a clock edge: out_valid=0, out_data=0, out_ch=0, rr_ptr=NCH-1 (so channel 0 has first priority), and all buffered content discarded.
REQ-028 in_ready SHALL be all 0 in any cycle where reset=1.
REQ-029 Reset asserted mid-transfer SHALL drop the held word with no output transfer.

Configuration
REQ-030 Macro ARB_MUX_SKID_EN defined: a second (skid) entry SHALL be present, and in_ready SHALL depend only on registered state (grant AND skid empty), never on out_ready.
REQ-031 With ARB_MUX_SKID_EN, an input accepted while the output is stalled SHALL go to the skid entry and move to the output register on the next output transfer.
REQ-032 With ARB_MUX_SKID_EN, two words can be held, and in_ready SHALL be all 0 while the skid entry is full.
REQ-033 Macro ARB_MUX_SKID_EN undefined: a single entry SHALL be present, and the grant's in_ready = grant AND (!out_valid OR out_ready).

Verification
REQ-034 Explicit mode, NCH=4, sel=2, in_valid=4'b1111, ch2 data 7'h55, out_ready=1 -> in_ready=4'b0100; next cycle out_data=7'h55, out_ch=2.
REQ-035 Round-robin after reset, all channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,0, one word per cycle.
REQ-036 Round-robin, only ch3 valid, then ch1 valid -> grants 3 then 1; rr_ptr=1 afterwards.
REQ-037 out_ready=0 for 5 cycles with ch0 streaming -> out_data stable; no skid: 1 word accepted; ARB_MUX_SKID_EN: 2 words accepted; release -> words emerge in order, none lost.
REQ-038 sel=NCH (out of range) with NCH=3, SELW=2 -> in_ready=0, out_valid stays 0.
REQ-039 reset pulsed while out_valid=1 with out_ready=0 -> next cycle out_valid=0 and out_ch=0; first round-robin grant thereafter is ch0.
